// File: rtl/arbiter_burst_planner.sv
// arbiter_burst_planner: sequential per-channel burst planner sharing one restoring divider and one multiplier.
// Define ARBITER_PLANNER_REMAINDER_EN to give the frame remainder to the highest-priority active channel.
module arbiter_burst_planner #(
   parameter int C_NUM_CHANNELS           = 4,
   parameter int C_TRANSACTION_SIZE_WIDTH = 32,
   parameter int C_PRIORITY_WIDTH         = 3,
   parameter int C_FRAME_SIZE             = 256,
   parameter int C_MAX_BURST_LEN          = 256
) (
   input  logic                                                  ACLK,
   input  logic                                                  ARESETN,
   input  logic                                                  start,
   input  logic [C_NUM_CHANNELS-1:0]                             active_channels,
   input  logic [C_PRIORITY_WIDTH*C_NUM_CHANNELS-1:0]            channels_priority,
   input  logic [C_TRANSACTION_SIZE_WIDTH*C_NUM_CHANNELS-1:0]    ch_transactions_sizes,
   output logic                                                  busy,
   output logic                                                  done,
   output logic                                                  plan_zero,
   output logic [($clog2(C_MAX_BURST_LEN)+1)*C_NUM_CHANNELS-1:0] beats_of_channels,
   output logic [C_TRANSACTION_SIZE_WIDTH*C_NUM_CHANNELS-1:0]    bursts_of_channels,
   output logic [($clog2(C_MAX_BURST_LEN)+1)*C_NUM_CHANNELS-1:0] last_burst_beats_of_channels
);
   localparam int N   = C_NUM_CHANNELS;
   localparam int W   = C_TRANSACTION_SIZE_WIDTH;
   localparam int PW  = C_PRIORITY_WIDTH;
   localparam int BW  = $clog2(C_MAX_BURST_LEN) + 1;
   localparam int IW  = (N > 1) ? $clog2(N) : 1;
   localparam int CW  = $clog2(W) + 1;
   localparam int PRW = W + PW + 1;
`ifdef ARBITER_PLANNER_REMAINDER_EN
   localparam bit REM_EN = 1'b1;
`else
   localparam bit REM_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_SUM, S_BASE_DIV, S_CH_SETUP, S_CH_DIV, S_DONE} state_t;

   state_t          state, state_n;
   logic [N-1:0]    snap_act, snap_act_n;
   logic [PW-1:0]   snap_prio [N], snap_prio_n [N], in_prio [N];
   logic [W-1:0]    snap_size [N], snap_size_n [N], in_size [N];
   logic [W-1:0]    total, total_n, sum_acc, base, base_n, base_rem, base_rem_n;
   logic [PW-1:0]   best_prio, best_prio_n;
   logic [IW-1:0]   best_idx, best_idx_n, ch, ch_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [W-1:0]    quo, quo_n, quo_d, dvs, dvs_n;
   logic [W:0]      rem, rem_n, rem_d, rem_sh;
   logic            ge, last_ch, last_it, ch_live, pz_n;
   logic [PRW-1:0]  full;
   logic [BW-1:0]   beats_c;
   logic [BW-1:0]   wk_beats [N], wk_beats_n [N], out_beats [N], out_beats_n [N];
   logic [W-1:0]    wk_bursts [N], wk_bursts_n [N], out_bursts [N], out_bursts_n [N];
   logic [BW-1:0]   wk_last [N], wk_last_n [N], out_last [N], out_last_n [N];

   for (genvar g = 0; g < N; g++) begin : g_ch
      assign in_prio[g] = channels_priority[g*PW +: PW];
      assign in_size[g] = ch_transactions_sizes[g*W +: W];
      assign beats_of_channels[g*BW +: BW]           = out_beats[g];
      assign bursts_of_channels[g*W +: W]            = out_bursts[g];
      assign last_burst_beats_of_channels[g*BW +: BW] = out_last[g];
   end

   assign busy    = (state != S_IDLE) && (state != S_DONE);
   assign done    = state == S_DONE;
   assign last_ch = ch == IW'(N - 1);
   assign last_it = cnt == CW'(W - 1);
   assign ch_live = snap_act[ch] && (snap_prio[ch] != '0);
   assign sum_acc = total + (snap_act[ch] ? W'(snap_prio[ch]) : '0);
   // One restoring-division step: shift in the next dividend bit, subtract if it fits
   assign rem_sh  = {rem[W-1:0], quo[W-1]};
   assign ge      = rem_sh >= {1'b0, dvs};
   assign rem_d   = ge ? rem_sh - {1'b0, dvs} : rem_sh;
   assign quo_d   = {quo[W-2:0], ge};
   assign full    = PRW'(base) * PRW'(snap_prio[ch]) + ((REM_EN && ch == best_idx) ? PRW'(base_rem) : '0);
   assign beats_c = (full > PRW'(C_MAX_BURST_LEN)) ? BW'(C_MAX_BURST_LEN) : (full == '0) ? BW'(1) : full[BW-1:0];

   always_comb begin
      state_n     = state;
      snap_act_n  = snap_act;
      snap_prio_n = snap_prio;
      snap_size_n = snap_size;
      total_n     = total;
      best_prio_n = best_prio;
      best_idx_n  = best_idx;
      base_n      = base;
      base_rem_n  = base_rem;
      ch_n        = ch;
      cnt_n       = cnt;
      quo_n       = quo;
      rem_n       = rem;
      dvs_n       = dvs;
      wk_beats_n  = wk_beats;
      wk_bursts_n = wk_bursts;
      wk_last_n   = wk_last;
      case (state)
         S_IDLE: if (start) begin
            state_n     = S_SUM;
            snap_act_n  = active_channels;
            snap_prio_n = in_prio;
            snap_size_n = in_size;
            total_n     = '0;
            best_prio_n = '0;
            best_idx_n  = '0;
            ch_n        = '0;
            wk_beats_n  = '{default: '0};
            wk_bursts_n = '{default: '0};
            wk_last_n   = '{default: '0};
         end
         S_SUM: begin
            total_n = sum_acc;
            if (snap_act[ch] && snap_prio[ch] > best_prio) begin
               best_prio_n = snap_prio[ch];
               best_idx_n  = ch;
            end
            ch_n = last_ch ? '0 : ch + IW'(1);
            if (last_ch) begin
               quo_n   = W'(C_FRAME_SIZE);
               rem_n   = '0;
               dvs_n   = sum_acc;
               cnt_n   = '0;
               state_n = (sum_acc == '0) ? S_DONE : S_BASE_DIV;
            end
         end
         S_BASE_DIV: begin
            quo_n = quo_d;
            rem_n = rem_d;
            cnt_n = cnt + CW'(1);
            if (last_it) begin
               base_n     = quo_d;
               base_rem_n = rem_d[W-1:0];
               state_n    = S_CH_SETUP;
            end
         end
         S_CH_SETUP: if (ch_live) begin
            wk_beats_n[ch] = beats_c;
            quo_n          = snap_size[ch];
            rem_n          = '0;
            dvs_n          = W'(beats_c);
            cnt_n          = '0;
            state_n        = S_CH_DIV;
         end else begin
            wk_beats_n[ch]  = '0;
            wk_bursts_n[ch] = '0;
            wk_last_n[ch]   = '0;
            ch_n            = last_ch ? '0 : ch + IW'(1);
            state_n         = last_ch ? S_DONE : S_CH_SETUP;
         end
         S_CH_DIV: begin
            quo_n = quo_d;
            rem_n = rem_d;
            cnt_n = cnt + CW'(1);
            if (last_it) begin
               wk_bursts_n[ch] = quo_d;
               wk_last_n[ch]   = rem_d[BW-1:0];
               ch_n            = last_ch ? '0 : ch + IW'(1);
               state_n         = last_ch ? S_DONE : S_CH_SETUP;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      out_beats_n  = out_beats;
      out_bursts_n = out_bursts;
      out_last_n   = out_last;
      pz_n         = plan_zero;
      // Results become visible together on the edge that enters DONE
      if (state != S_DONE && state_n == S_DONE) begin
         out_beats_n  = wk_beats_n;
         out_bursts_n = wk_bursts_n;
         out_last_n   = wk_last_n;
         pz_n         = state == S_SUM;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= S_IDLE;
         snap_act   <= '0;
         snap_prio  <= '{default: '0};
         snap_size  <= '{default: '0};
         total      <= '0;
         best_prio  <= '0;
         best_idx   <= '0;
         base       <= '0;
         base_rem   <= '0;
         ch         <= '0;
         cnt        <= '0;
         quo        <= '0;
         rem        <= '0;
         dvs        <= '0;
         wk_beats   <= '{default: '0};
         wk_bursts  <= '{default: '0};
         wk_last    <= '{default: '0};
         out_beats  <= '{default: '0};
         out_bursts <= '{default: '0};
         out_last   <= '{default: '0};
         plan_zero  <= 1'b0;
      end else begin
         state      <= state_n;
         snap_act   <= snap_act_n;
         snap_prio  <= snap_prio_n;
         snap_size  <= snap_size_n;
         total      <= total_n;
         best_prio  <= best_prio_n;
         best_idx   <= best_idx_n;
         base       <= base_n;
         base_rem   <= base_rem_n;
         ch         <= ch_n;
         cnt        <= cnt_n;
         quo        <= quo_n;
         rem        <= rem_n;
         dvs        <= dvs_n;
         wk_beats   <= wk_beats_n;
         wk_bursts  <= wk_bursts_n;
         wk_last    <= wk_last_n;
         out_beats  <= out_beats_n;
         out_bursts <= out_bursts_n;
         out_last   <= out_last_n;
         plan_zero  <= pz_n;
      end
   end
endmodule

// File: tb/tb_arbiter_burst_planner.sv
// tb_arbiter_burst_planner: three planners (frames 256, 1024, 16) on shared stimulus, checked every cycle
// against a plan-level reference model plus hand-computed literals.
module tb_arbiter_burst_planner;
   localparam int N = 4, W = 32, PW = 3, BW = 9, MAXB = 256, K = 3;
`ifdef ARBITER_PLANNER_REMAINDER_EN
   localparam bit REM = 1'b1;
`else
   localparam bit REM = 1'b0;
`endif

   logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [N-1:0]     act_bus = '0;
   logic [N*PW-1:0]  prio_bus = '0;
   logic [N*W-1:0]   size_bus = '0;
   logic             busy_w [K], done_w [K], pz_w [K];
   logic [N*BW-1:0]  beats_w [K], last_w [K];
   logic [N*W-1:0]   bursts_w [K];

   always #5 clk = ~clk;

   for (genvar g = 0; g < K; g++) begin : g_dut
      arbiter_burst_planner #(
         .C_NUM_CHANNELS(N), .C_TRANSACTION_SIZE_WIDTH(W), .C_PRIORITY_WIDTH(PW),
         .C_FRAME_SIZE(g == 0 ? 256 : (g == 1 ? 1024 : 16)), .C_MAX_BURST_LEN(MAXB)
      ) dut (
         .ACLK(clk), .ARESETN(rst_n), .start(start), .active_channels(act_bus),
         .channels_priority(prio_bus), .ch_transactions_sizes(size_bus),
         .busy(busy_w[g]), .done(done_w[g]), .plan_zero(pz_w[g]),
         .beats_of_channels(beats_w[g]), .bursts_of_channels(bursts_w[g]),
         .last_burst_beats_of_channels(last_w[g])
      );
   end

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string nm, input int k, input int ch, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s dut%0d ch%0d: got %0d, expected %0d at %0t", nm, k, ch, got, exp, $time);
      end
   endtask

   function automatic int fr(int k);
      return k == 0 ? 256 : (k == 1 ? 1024 : 16);
   endfunction
   function automatic longint d_beats(int k, int ch);
      return longint'(beats_w[k][ch*BW +: BW]);
   endfunction
   function automatic longint d_bursts(int k, int ch);
      return longint'(bursts_w[k][ch*W +: W]);
   endfunction
   function automatic longint d_last(int k, int ch);
      return longint'(last_w[k][ch*BW +: BW]);
   endfunction

   // Reference model: whole plan computed from the arithmetic rules when start is accepted,
   // released as a unit after the plan's latency.
   int     m_cnt;
   bit     m_busy, m_done, m_pz, p_pz;
   longint m_beats [K][N], m_bursts [K][N], m_last [K][N];
   longint p_beats [K][N], p_bursts [K][N], p_last [K][N];

   task automatic m_reset();
      m_cnt = 0; m_busy = 0; m_done = 0; m_pz = 0;
      for (int k = 0; k < K; k++)
         for (int c = 0; c < N; c++) begin
            m_beats[k][c] = 0; m_bursts[k][c] = 0; m_last[k][c] = 0;
         end
   endtask

   task automatic m_plan();
      int tot = 0, best = -1, bp = 0, lat = N + 1;
      longint full, b, sz;
      for (int c = 0; c < N; c++)
         if (act_bus[c]) begin
            tot += int'(prio_bus[c*PW +: PW]);
            if (int'(prio_bus[c*PW +: PW]) > bp) begin bp = int'(prio_bus[c*PW +: PW]); best = c; end
         end
      p_pz = tot == 0;
      if (tot != 0) begin
         lat += W;
         for (int c = 0; c < N; c++) lat += (act_bus[c] && prio_bus[c*PW +: PW] != 0) ? 1 + W : 1;
      end
      for (int k = 0; k < K; k++)
         for (int c = 0; c < N; c++) begin
            p_beats[k][c] = 0; p_bursts[k][c] = 0; p_last[k][c] = 0;
            if (tot != 0 && act_bus[c] && prio_bus[c*PW +: PW] != 0) begin
               full = longint'(fr(k) / tot) * longint'(prio_bus[c*PW +: PW]) + ((REM && c == best) ? fr(k) % tot : 0);
               b = full > MAXB ? MAXB : (full == 0 ? 1 : full);
               sz = longint'(size_bus[c*W +: W]);
               p_beats[k][c] = b; p_bursts[k][c] = sz / b; p_last[k][c] = sz % b;
            end
         end
      m_cnt = lat - 1;
      m_busy = 1;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else if (m_done) m_done = 0;
         else if (m_cnt == 0) begin
            if (start) m_plan();
         end else if (m_cnt == 1) begin
            m_cnt = 0; m_busy = 0; m_done = 1; m_pz = p_pz;
            m_beats = p_beats; m_bursts = p_bursts; m_last = p_last;
         end else m_cnt--;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n)
         for (int k = 0; k < K; k++) begin
            chk("busy", k, 0, longint'(busy_w[k]), longint'(m_busy));
            chk("done", k, 0, longint'(done_w[k]), longint'(m_done));
            chk("plan_zero", k, 0, longint'(pz_w[k]), longint'(m_pz));
            for (int c = 0; c < N; c++) begin
               chk("beats", k, c, d_beats(k, c), m_beats[k][c]);
               chk("bursts", k, c, d_bursts(k, c), m_bursts[k][c]);
               chk("last", k, c, d_last(k, c), m_last[k][c]);
            end
         end
   end

   task automatic set_ch(input int c, input int p, input longint s);
      prio_bus[c*PW +: PW] = PW'(p);
      size_bus[c*W +: W]   = W'(s);
   endtask

   task automatic scramble();
      act_bus  = N'($urandom);
      prio_bus = (N*PW)'($urandom);
      for (int c = 0; c < N; c++) size_bus[c*W +: W] = $urandom;
   endtask

   // Pulses start, then counts cycles until done; cycle 1 is the one after the accepting edge.
   task automatic go(output int lat, input bit glitch);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      lat = 1;
      while (!done_w[0] && lat < 400) begin
         @(negedge clk);
         lat++;
         start = glitch && (lat == 20 || $urandom_range(0, 7) == 0);
      end
      start = 1'b0;
      if (lat >= 400) chk("done_timeout", 0, 0, 1, 0);
   endtask

   initial begin
      int lat, nd;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", 0, 0, longint'(busy_w[0]), 0);
      chk("rst_done", 0, 0, longint'(done_w[0]), 0);
      chk("rst_plan_zero", 0, 0, longint'(pz_w[0]), 0);
      chk("rst_beats", 0, 0, longint'(beats_w[0] != '0), 0);
      chk("rst_bursts", 0, 0, longint'(bursts_w[0] != '0), 0);
      chk("rst_last", 0, 0, longint'(last_w[0] != '0), 0);

      act_bus = 4'b1111;
      set_ch(0, 1, 1000); set_ch(1, 1, 64); set_ch(2, 1, 0); set_ch(3, 1, 65);
      go(lat, 0);
      chk("t1_latency", 0, 0, lat, 169);
      for (int c = 0; c < N; c++) chk("t1_beats", 0, c, d_beats(0, c), 64);
      chk("t1_bursts", 0, 0, d_bursts(0, 0), 15); chk("t1_last", 0, 0, d_last(0, 0), 40);
      chk("t1_bursts", 0, 1, d_bursts(0, 1), 1);  chk("t1_last", 0, 1, d_last(0, 1), 0);
      chk("t1_bursts", 0, 2, d_bursts(0, 2), 0);  chk("t1_last", 0, 2, d_last(0, 2), 0);
      chk("t1_bursts", 0, 3, d_bursts(0, 3), 1);  chk("t1_last", 0, 3, d_last(0, 3), 1);
      chk("t1_plan_zero", 0, 0, longint'(pz_w[0]), 0);
      repeat (2) @(negedge clk);

      act_bus = 4'b0001;
      set_ch(0, 3, 600); set_ch(1, 5, 100); set_ch(2, 7, 100); set_ch(3, 0, 100);
      go(lat, 0);
      chk("t2_latency", 0, 0, lat, 73);
      chk("t2_beats", 0, 0, d_beats(0, 0), REM ? 256 : 255);
      chk("t2_bursts", 0, 0, d_bursts(0, 0), 2);
      chk("t2_last", 0, 0, d_last(0, 0), REM ? 88 : 90);
      chk("t2_beats", 0, 1, d_beats(0, 1), 0);
      chk("t2_bursts", 0, 2, d_bursts(0, 2), 0);
      repeat (2) @(negedge clk);

      act_bus = 4'b0001;
      set_ch(0, 1, 1000); set_ch(1, 0, 0); set_ch(2, 0, 0); set_ch(3, 0, 0);
      go(lat, 0);
      chk("t3_beats", 1, 0, d_beats(1, 0), 256);
      chk("t3_bursts", 1, 0, d_bursts(1, 0), 3);
      chk("t3_last", 1, 0, d_last(1, 0), 232);
      repeat (2) @(negedge clk);

      act_bus = 4'b0000;
      for (int c = 0; c < N; c++) set_ch(c, 5, 77);
      go(lat, 0);
      chk("t4a_latency", 0, 0, lat, 5);
      chk("t4a_plan_zero", 0, 0, longint'(pz_w[0]), 1);
      chk("t4a_beats", 0, 0, longint'(beats_w[0] != '0), 0);
      repeat (2) @(negedge clk);
      act_bus = 4'b1111;
      for (int c = 0; c < N; c++) set_ch(c, 0, 77);
      go(lat, 0);
      chk("t4b_latency", 0, 0, lat, 5);
      chk("t4b_plan_zero", 0, 0, longint'(pz_w[0]), 1);
      chk("t4b_bursts", 0, 0, longint'(bursts_w[0] != '0), 0);
      repeat (2) @(negedge clk);

      act_bus = 4'b1111;
      for (int c = 0; c < N; c++) set_ch(c, 7, 5);
      go(lat, 0);
      chk("t5_beats", 2, 1, d_beats(2, 1), 1);
      chk("t5_bursts", 2, 1, d_bursts(2, 1), 5);
      chk("t5_last", 2, 1, d_last(2, 1), 0);
      chk("t5_beats", 2, 0, d_beats(2, 0), REM ? 16 : 1);
      chk("t5_bursts", 2, 0, d_bursts(2, 0), REM ? 0 : 5);
      repeat (2) @(negedge clk);

      act_bus = 4'b1111;
      set_ch(0, 1, 1000); set_ch(1, 1, 64); set_ch(2, 1, 0); set_ch(3, 1, 65);
      go(lat, 1);
      chk("t6_latency", 0, 0, lat, 169);
      nd = 0;
      repeat (200) begin
         @(negedge clk);
         if (done_w[0]) nd++;
      end
      chk("t6_extra_done", 0, 0, nd, 0);

      act_bus = 4'b1111;
      set_ch(0, 2, 999); set_ch(1, 1, 64); set_ch(2, 3, 0); set_ch(3, 1, 65);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_busy", 0, 0, longint'(busy_w[0]), 0);
      chk("t7_done", 0, 0, longint'(done_w[0]), 0);
      chk("t7_beats", 0, 0, longint'(beats_w[0] != '0), 0);
      chk("t7_bursts", 0, 0, longint'(bursts_w[0] != '0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      act_bus = 4'b1111;
      set_ch(0, 1, 1000); set_ch(1, 1, 64); set_ch(2, 1, 0); set_ch(3, 1, 65);
      go(lat, 0);
      chk("t7_latency", 0, 0, lat, 169);
      chk("t7_beats_after", 0, 2, d_beats(0, 2), 64);

      for (int it = 0; it < 30; it++) begin
         act_bus = N'($urandom);
         for (int c = 0; c < N; c++)
            set_ch(c, $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom_range(0, 3000)));
         if ($urandom_range(0, 9) == 0) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(1, 60)) @(negedge clk);
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else go(lat, 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/arbiter_burst_planner.md
Name: arbiter_burst_planner

Overview:
- Sequential, parametrised successor to the arbiter's combinational beats/bursts calculator.
- On a start pulse, samples the channel set, priorities and transaction sizes.
- Splits an arbitration frame of beats across the active channels in proportion to priority, using one shared iterative divider instead of per-channel combinational dividers.
- Produces per-channel burst length, full-burst count and last-burst beats, held until the next plan; feeds the DMA arbiter/AXI burst issue logic.

Parameters:
- C_NUM_CHANNELS, 4, number of arbitrated channels (>=1)
- C_TRANSACTION_SIZE_WIDTH, 32, width of transaction sizes, burst counts and divider iterations (W)
- C_PRIORITY_WIDTH, 3, width of each channel priority
- C_FRAME_SIZE, 256, beats per arbitration frame (constant dividend, < 2^W)
- C_MAX_BURST_LEN, 256, AXI4 max beats per burst; BW = $clog2(C_MAX_BURST_LEN)+1

Ports:
- ACLK  in  1  clock; the block's one clock
- ARESETN  in  1  reset; asynchronous, active-low
- start  in  1  request a new plan; accepted only in IDLE
- active_channels  in  C_NUM_CHANNELS  per-channel enable
- channels_priority  in  C_PRIORITY_WIDTH x C_NUM_CHANNELS  priority weights
- ch_transactions_sizes  in  W x C_NUM_CHANNELS  beats to move per channel
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; outputs valid from this cycle
- plan_zero  out  1  set at done when total active priority == 0
- beats_of_channels  out  BW x C_NUM_CHANNELS  beats per full burst
- bursts_of_channels  out  W x C_NUM_CHANNELS  number of full bursts
- last_burst_beats_of_channels  out  BW x C_NUM_CHANNELS  beats in trailing partial burst (0 = none)

Behaviour:
- Reset (async, any state): IDLE; busy, done and plan_zero = 0; all output arrays = 0; internal snapshot and divider cleared.
- start in IDLE: snapshot all inputs in the same edge; inputs are ignored afterwards. start while busy: ignored, no queuing.
- FSM: IDLE -> SUM -> BASE_DIV -> CH_SETUP/CH_DIV loop -> DONE -> IDLE.
- SUM: N cycles, one channel per cycle, accumulates the priority of each active channel. If total == 0: go to DONE with plan_zero = 1 and all arrays = 0.
- BASE_DIV: W cycles of restoring division; base = C_FRAME_SIZE / total. The remainder is kept for the optional feature.
- Channels are processed in ascending index order.
- CH_SETUP (1 cycle), inactive channel or priority 0: beats, bursts and last = 0; move to next channel.
- CH_SETUP, active channel with priority > 0: beats = min(base*prio, C_MAX_BURST_LEN); if beats == 0, beats = 1. No divide-by-zero is reachable.
- CH_DIV (W cycles): bursts = size / beats; last = size % beats. size == 0 gives 0/0.
- Output arrays update only at DONE, all in the same cycle; they hold until the next done. Stale values remain visible while busy.
- DONE: done = 1 for one cycle, busy = 0; return to IDLE. A new start is accepted in the following cycle.
- Latency, start edge to done cycle: N + W + sum over channels of (1 + W*[active and prio>0]) + 1. Zero-total case: N + 1.
- Multiplier: one shared unit, base (W bits) x prio; compare at full width before clamping.

Optional Feature:
- Macro: ARBITER_PLANNER_REMAINDER_EN.
- Defined: the leftover frame beats (C_FRAME_SIZE % total) are added to the single active channel with the highest priority (lowest index on ties) before clamping. Latency is unchanged.
- Undefined: the leftover is discarded and all channels get base*prio.

Test Plan:
- N=4, FRAME=256; all active; prio 1,1,1,1; sizes 1000,64,0,65 -> beats 64,64,64,64; bursts 15,1,0,1; last 40,0,0,1; done exactly 169 cycles after start.
- Only ch0 active, prio 3, size 600 -> beats 255, bursts 2, last 90; other channels all 0. With ARBITER_PLANNER_REMAINDER_EN: beats 256, bursts 2, last 88.
- FRAME=1024; only ch0 active, prio 1, size 1000 -> beats clamped to 256, bursts 3, last 232.
- All inactive, or active with prio 0 -> done after N+1=5 cycles; plan_zero = 1; all arrays 0.
- Prio 7,7,7,7, FRAME=16 (base 0) -> every beats = 1; size 5 -> bursts 5, last 0.
- Second start mid-plan -> ignored, single done. ARESETN low mid-plan -> busy, done and arrays 0 immediately; next start completes normally.
